instruction_fetch: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline; producer side of the IF/ID interface the decoder consumes.

---
 rtl/instruction_fetch_pkg.sv | 19 +
 rtl/instruction_memory.sv | 22 ++
 rtl/instruction_fetch.sv | 82 ++++++++
 tb/tb_instruction_fetch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared widths, PCSrc encodings and instruction constants for the IF stage.
package instruction_fetch_pkg;

  localparam int PC_BITS            = 32;
  localparam int INSTRUCTION_BITS   = 32;
  localparam int INST_MEM_ADDR_BITS = 8;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [5:0] OPCODE_HALT = 6'b111111;
  localparam logic [INSTRUCTION_BITS-1:0] NOP_INSTRUCTION = '0;

  function automatic logic is_halt(input logic [INSTRUCTION_BITS-1:0] instr);
    return instr[INSTRUCTION_BITS-1 -: 6] == OPCODE_HALT;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: synchronous debug write, asynchronous fetch read, no reset.
module instruction_memory #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC selection, instruction memory and the IF/ID register.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_enable,
  input  logic                          i_PCWrite,
  input  logic                          i_if_id_write,
  input  logic [1:0]                    i_PCSrc,
  input  logic [PC_BITS-1:0]            i_branch_address,
  input  logic [PC_BITS-1:0]            i_jump_address,
  input  logic                          i_mem_wr_en,
  input  logic [INST_MEM_ADDR_BITS-1:0] i_mem_wr_addr,
  input  logic [INSTRUCTION_BITS-1:0]   i_mem_wr_data,
  output logic [INSTRUCTION_BITS-1:0]   o_instruction,
  output logic [PC_BITS-1:0]            o_PCNext,
  output logic [PC_BITS-1:0]            o_PC,
  output logic                          o_halt
);

  logic [PC_BITS-1:0]          pc;
  logic [PC_BITS-1:0]          pc_plus4;
  logic [PC_BITS-1:0]          pc_next;
  logic [INSTRUCTION_BITS-1:0] fetched;
  logic                        redirect;
  logic                        fetch_halt;
  logic                        advance;

  // Debug writes only land while the pipeline is parked.
  instruction_memory #(
    .ADDR_BITS(INST_MEM_ADDR_BITS),
    .DATA_BITS(INSTRUCTION_BITS)
  ) u_mem (
    .clk    (clk),
    .wr_en  (i_mem_wr_en & ~i_enable),
    .wr_addr(i_mem_wr_addr),
    .wr_data(i_mem_wr_data),
    .rd_addr(pc[INST_MEM_ADDR_BITS+1:2]),
    .rd_data(fetched)
  );

  // Stall contract with ID: PCWrite=0 freezes the PC, if_id_write=0 freezes IF/ID;
  // a branch/jump redirect overrides both and flushes IF/ID to NOP.
  always_comb begin
    pc_plus4   = pc + PC_BITS'(4);
    redirect   = (i_PCSrc == PCSRC_BRANCH) || (i_PCSrc == PCSRC_JUMP);
    fetch_halt = i_if_id_write && is_halt(fetched);
    advance    = i_enable && !o_halt;
    pc_next    = pc;
    if (redirect)
      pc_next = (i_PCSrc == PCSRC_JUMP) ? i_jump_address : i_branch_address;
    else if (i_PCWrite && !fetch_halt)
      pc_next = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= '0;
      o_instruction <= NOP_INSTRUCTION;
      o_PCNext      <= '0;
      o_halt        <= 1'b0;
    end else if (advance) begin
      pc <= pc_next;
      if (redirect) begin
        o_instruction <= NOP_INSTRUCTION;
        o_PCNext      <= '0;
      end else if (i_if_id_write) begin
        o_instruction <= fetched;
        o_PCNext      <= pc_plus4;
        if (fetch_halt) o_halt <= 1'b1;
      end
    end else if (i_enable) begin
      // Halted: PC stays frozen while NOPs drain the rest of the pipeline.
      o_instruction <= NOP_INSTRUCTION;
      o_PCNext      <= '0;
    end
  end

  assign o_PC = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written halt/reset sequences, random run vs model.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable, i_PCWrite, i_if_id_write;
  logic [1:0]  i_PCSrc;
  logic [31:0] i_branch_address, i_jump_address;
  logic        i_mem_wr_en;
  logic [7:0]  i_mem_wr_addr;
  logic [31:0] i_mem_wr_data;
  logic [31:0] o_instruction, o_PCNext, o_PC;
  logic        o_halt;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_PCWrite(i_PCWrite),
    .i_if_id_write(i_if_id_write), .i_PCSrc(i_PCSrc),
    .i_branch_address(i_branch_address), .i_jump_address(i_jump_address),
    .i_mem_wr_en(i_mem_wr_en), .i_mem_wr_addr(i_mem_wr_addr), .i_mem_wr_data(i_mem_wr_data),
    .o_instruction(o_instruction), .o_PCNext(o_PCNext), .o_PC(o_PC), .o_halt(o_halt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic pw, input logic iw, input logic [1:0] src,
                       input logic [31:0] br, input logic [31:0] jmp);
    i_enable = en; i_PCWrite = pw; i_if_id_write = iw; i_PCSrc = src;
    i_branch_address = br; i_jump_address = jmp; i_mem_wr_en = 1'b0;
  endtask

  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    i_enable = 1'b0; i_mem_wr_en = 1'b1; i_mem_wr_addr = addr; i_mem_wr_data = data;
    tick();
    i_mem_wr_en = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ei, input logic [31:0] epn,
                         input logic [31:0] epc, input logic eh);
    chk({tag, "_instr"},  o_instruction, ei);
    chk({tag, "_pcnext"}, o_PCNext, epn);
    chk({tag, "_pc"},     o_PC, epc);
    chk({tag, "_halt"},   {31'd0, o_halt}, {31'd0, eh});
  endtask

  function automatic logic [31:0] m(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        en, pw, iw;
    logic [1:0]  src;
    logic [31:0] br, jmp;
    logic [31:0] e_instr, e_pcnext, e_pc;
    logic        e_halt;
  } vec_t;

  function automatic vec_t v(input logic en, input logic pw, input logic iw, input logic [1:0] src,
                             input logic [31:0] br, input logic [31:0] jmp, input logic [31:0] ei,
                             input logic [31:0] epn, input logic [31:0] epc);
    vec_t r;
    r.en = en; r.pw = pw; r.iw = iw; r.src = src; r.br = br; r.jmp = jmp;
    r.e_instr = ei; r.e_pcnext = epn; r.e_pc = epc; r.e_halt = 1'b0;
    return r;
  endfunction

  vec_t vecs[14];

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [256];
  logic [31:0] m_pc, m_instr, m_pcnext;
  logic        m_halt;

  // Applies one clock edge of the stage's rules using the inputs currently driven.
  task automatic model_step();
    logic [31:0] word;
    logic        hit;
    word = ref_mem[m_pc[9:2]];
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pcnext = 0; m_halt = 1'b0;
    end else if (i_enable && m_halt) begin
      m_instr = 0; m_pcnext = 0;
    end else if (i_enable) begin
      if (i_PCSrc == 2'b01 || i_PCSrc == 2'b10) begin
        m_pc = (i_PCSrc == 2'b10) ? i_jump_address : i_branch_address;
        m_instr = 0; m_pcnext = 0;
      end else begin
        hit = i_if_id_write && (word[31:26] == 6'h3f);
        if (i_if_id_write) begin
          m_instr = word; m_pcnext = m_pc + 32'd4;
        end
        if (hit) m_halt = 1'b1;
        if (i_PCWrite && !hit) m_pc = m_pc + 32'd4;
      end
    end
    if (i_mem_wr_en && !i_enable) ref_mem[i_mem_wr_addr] = i_mem_wr_data;
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    i_mem_wr_addr = '0; i_mem_wr_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk_all("reset", 32'd0, 32'd0, 32'd0, 1'b0);

    for (int i = 0; i < 32; i++) load(8'(i), m(i));
    chk_all("load_hold", 32'd0, 32'd0, 32'd0, 1'b0);

    vecs[0]  = v(1'b1, 1'b1, 1'b1, 2'b00, 32'd0, 32'd0, m(0), 32'd4, 32'd4);
    vecs[1]  = v(1'b1, 1'b1, 1'b1, 2'b00, 32'd0, 32'd0, m(1), 32'd8, 32'd8);
    vecs[2]  = v(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, m(1), 32'd8, 32'd8);
    vecs[3]  = v(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, m(1), 32'd8, 32'd8);
    vecs[4]  = v(1'b1, 1'b1, 1'b1, 2'b00, 32'd0, 32'd0, m(2), 32'd12, 32'd12);
    vecs[5]  = v(1'b1, 1'b1, 1'b1, 2'b00, 32'd0, 32'd0, m(3), 32'd16, 32'd16);
    vecs[6]  = v(1'b1, 1'b1, 1'b1, 2'b10, 32'd0, 32'h20, 32'd0, 32'd0, 32'h20);
    vecs[7]  = v(1'b1, 1'b1, 1'b1, 2'b00, 32'd0, 32'd0, m(8), 32'h24, 32'h24);
    vecs[8]  = v(1'b1, 1'b0, 1'b0, 2'b01, 32'h40, 32'd0, 32'd0, 32'd0, 32'h40);
    vecs[9]  = v(1'b1, 1'b1, 1'b1, 2'b00, 32'd0, 32'd0, m(16), 32'h44, 32'h44);
    vecs[10] = v(1'b1, 1'b1, 1'b1, 2'b11, 32'h80, 32'h80, m(17), 32'h48, 32'h48);
    vecs[11] = v(1'b0, 1'b1, 1'b1, 2'b10, 32'd0, 32'h80, m(17), 32'h48, 32'h48);
    vecs[12] = v(1'b1, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, m(18), 32'h4C, 32'h48);
    vecs[13] = v(1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0, m(18), 32'h4C, 32'h4C);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].en, vecs[i].pw, vecs[i].iw, vecs[i].src, vecs[i].br, vecs[i].jmp);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_pcnext, vecs[i].e_pc, vecs[i].e_halt);
    end

    // Halt at mem[2]; enabled-cycle memory write must be dropped.
    load(8'd2, 32'hFC00_0000);
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 2'b00, 32'd0, 32'd0);
    tick(); chk_all("halt_c1", m(0), 32'd4, 32'd4, 1'b0);
    tick(); chk_all("halt_c2", m(1), 32'd8, 32'd8, 1'b0);
    tick(); chk_all("halt_c3", 32'hFC00_0000, 32'd12, 32'd8, 1'b1);
    i_mem_wr_en = 1'b1; i_mem_wr_addr = 8'd3; i_mem_wr_data = 32'hDEAD_BEEF;
    tick(); chk_all("halt_drain", 32'd0, 32'd0, 32'd8, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 2'b10, 32'd0, 32'h40);
    tick(); chk_all("halt_jump", 32'd0, 32'd0, 32'd8, 1'b1);
    load(8'd2, m(2));
    rst = 1'b1; tick(); rst = 1'b0;
    chk_all("halt_rst", 32'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 2'b10, 32'd0, 32'h0C);
    tick();
    drive(1'b1, 1'b1, 1'b1, 2'b00, 32'd0, 32'd0);
    tick(); chk_all("wr_ignored", m(3), 32'h10, 32'h10, 1'b0);

    // Disabled: outputs hold even when the word under PC is rewritten; memory survives reset.
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'd0, 32'h40);
    i_mem_wr_en = 1'b1; i_mem_wr_addr = 8'd4; i_mem_wr_data = 32'h5555_0004;
    tick(); chk_all("dis_samewr", m(3), 32'h10, 32'h10, 1'b0);
    i_mem_wr_addr = 8'd5; i_mem_wr_data = 32'hABCD_0005;
    tick(); chk_all("dis_hold", m(3), 32'h10, 32'h10, 1'b0);
    i_mem_wr_en = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk_all("dis_rst", 32'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 2'b10, 32'd0, 32'h14);
    tick();
    drive(1'b1, 1'b1, 1'b1, 2'b00, 32'd0, 32'd0);
    tick(); chk_all("mem_kept", 32'hABCD_0005, 32'h18, 32'h18, 1'b0);

    // Random run against the reference model.
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      load(8'(i), ref_mem[i]);
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    m_pc = 0; m_instr = 0; m_pcnext = 0; m_halt = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst              = ($urandom_range(0, 39) == 0);
      i_enable         = ($urandom_range(0, 7) != 0);
      i_PCWrite        = ($urandom_range(0, 3) != 0);
      i_if_id_write    = ($urandom_range(0, 3) != 0);
      i_PCSrc          = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) i_PCSrc = 2'b00;
      i_branch_address = $urandom;
      i_jump_address   = $urandom;
      i_mem_wr_en      = ($urandom_range(0, 1) == 1);
      i_mem_wr_addr    = 8'($urandom_range(0, 255));
      i_mem_wr_data    = $urandom;
      model_step();
      tick();
      chk_all($sformatf("rnd%0d", c), m_instr, m_pcnext, m_pc, m_halt);
    end
    rst = 1'b0; i_mem_wr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
